// File: rtl/sv_types_bus0.sv
// Shared bus0 types: master index map plus the master arbiter's state type and defaults.
package sv_types_bus0;

   localparam int CFG_BUS0_XMST_WORKGROUP = 0;
   localparam int CFG_BUS0_XMST_ETHMAC    = 1;
   localparam int CFG_BUS0_XMST_MSTUART   = 2;
   localparam int CFG_BUS0_XMST_DMI       = 3;
   localparam int CFG_BUS0_XMST_TOTAL     = 4;

   localparam int CFG_BUS0_ARB_TIMEOUT_DEF = 1024;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } bus0_arb_state_t;

endpackage

// File: rtl/bus0_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr, wrapping.
module bus0_rr_pick #(
   parameter int  N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int k;

   // Scan from the farthest offset down so the closest request to ptr is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      k     = 0;
      for (int off = N - 1; off >= 0; off--) begin
         k = (int'(ptr) + off) % N;
         if (req[k]) begin
            valid = 1'b1;
            idx   = IW'(k);
         end
      end
   end

endmodule

// File: rtl/bus0_master_arbiter.sv
// bus0 master arbiter: single-owner grant with round-robin (optional DMI priority),
// release on done or watchdog expiry, zero-bubble handoff between owners.
module bus0_master_arbiter
   import sv_types_bus0::*;
#(
   parameter int NMST     = CFG_BUS0_XMST_TOTAL,
   parameter int DMI_PRIO = 1,
   parameter int TIMEOUT  = CFG_BUS0_ARB_TIMEOUT_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NMST-1:0]          i_req,
   input  logic                     i_done,
   output logic [NMST-1:0]          o_gnt,
   output logic [$clog2(NMST)-1:0]  o_owner,
   output logic                     o_busy,
   output logic                     o_timeout,
   output logic [$clog2(NMST)-1:0]  o_err_mst
);

   localparam int              OW       = $clog2(NMST);
   localparam bit              DMI_EN   = (DMI_PRIO != 0) && (CFG_BUS0_XMST_DMI < NMST);
   localparam int              DMI_IDX  = (CFG_BUS0_XMST_DMI < NMST) ? CFG_BUS0_XMST_DMI : 0;
   localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);
   localparam logic [OW-1:0]   OWN_LAST = OW'(NMST - 1);
   localparam logic [NMST-1:0] ONE      = NMST'(1);

   bus0_arb_state_t state_reg, state_next;
   logic [NMST-1:0] gnt_reg, gnt_next;
   logic [OW-1:0]   owner_reg, owner_next;
   logic            busy_reg, busy_next;
   logic            timeout_reg, timeout_next;
   logic [OW-1:0]   err_mst_reg, err_mst_next;
   logic [OW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [15:0]     cnt_reg, cnt_next;

   logic [NMST-1:0] owner_oh, others, pick_req;
   logic [OW-1:0]   ptr_rel, pick_ptr, rr_idx, win_idx;
   logic            rr_valid, win_valid, release_now, wd_expire;

   genvar gi;
   generate
      for (gi = 0; gi < NMST; gi++) begin : g_owner_oh
         assign owner_oh[gi] = (owner_reg == OW'(gi));
      end
   endgenerate

   always_comb begin
      release_now = (state_reg == ARB_OWNED) && (i_done || (cnt_reg == WD_LAST));
      wd_expire   = (state_reg == ARB_OWNED) && !i_done && (cnt_reg == WD_LAST);

      // A DMI release under fixed priority leaves the rotation where it was.
      if (DMI_EN && (owner_reg == OW'(DMI_IDX)))
         ptr_rel = rr_ptr_reg;
      else if (owner_reg == OWN_LAST)
         ptr_rel = '0;
      else
         ptr_rel = owner_reg + OW'(1);

      // The releasing owner may only win again when nobody else is asking.
      others   = i_req & ~owner_oh;
      pick_req = ((state_reg == ARB_OWNED) && (others != '0)) ? others : i_req;
      pick_ptr = (state_reg == ARB_OWNED) ? ptr_rel : rr_ptr_reg;
   end

   bus0_rr_pick #(.N(NMST)) u_rr_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .valid (rr_valid),
      .idx   (rr_idx)
   );

   always_comb begin
      win_valid = rr_valid;
      win_idx   = rr_idx;
      if (DMI_EN && pick_req[DMI_IDX])
         win_idx = OW'(DMI_IDX);
   end

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      owner_next   = owner_reg;
      busy_next    = busy_reg;
      timeout_next = 1'b0;
      err_mst_next = err_mst_reg;
      rr_ptr_next  = rr_ptr_reg;
      cnt_next     = cnt_reg;

      case (state_reg)
         ARB_IDLE: begin
            if (win_valid) begin
               state_next = ARB_OWNED;
               owner_next = win_idx;
               gnt_next   = ONE << win_idx;
               busy_next  = 1'b1;
               cnt_next   = '0;
            end
         end
         ARB_OWNED: begin
            if (release_now) begin
               rr_ptr_next  = ptr_rel;
               timeout_next = wd_expire;
               if (wd_expire)
                  err_mst_next = owner_reg;
               if (win_valid) begin
                  owner_next = win_idx;
                  gnt_next   = ONE << win_idx;
                  cnt_next   = '0;
               end else begin
                  state_next = ARB_IDLE;
                  gnt_next   = '0;
                  busy_next  = 1'b0;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         default: begin
            state_next = ARB_IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg   <= ARB_IDLE;
         gnt_reg     <= '0;
         owner_reg   <= '0;
         busy_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         err_mst_reg <= '0;
         rr_ptr_reg  <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         owner_reg   <= owner_next;
         busy_reg    <= busy_next;
         timeout_reg <= timeout_next;
         err_mst_reg <= err_mst_next;
         rr_ptr_reg  <= rr_ptr_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign o_gnt     = gnt_reg;
   assign o_owner   = owner_reg;
   assign o_busy    = busy_reg;
   assign o_timeout = timeout_reg;
   assign o_err_mst = err_mst_reg;

endmodule
